// File: rtl/discharge_param_scheduler.sv
// discharge_param_scheduler
// Collects asynchronous parameter-change requests (Ton, Toff, Ip, waveform)
// into shadow registers and commits them to the live outputs only inside a
// safe window: Ton/Toff/Ip when machining is idle or the generator is in its
// Toff/deion phase, the waveform word only when machining is idle. Every
// commit is followed by a one-cycle SETTLE state that raises update_strobe.
// A stale counter flags requests that have been waiting too long.
//
// Optional feature macro: PARAM_CLAMP_EN
//   defined   : shadows load range-clamped values and clamp_flag pulses one
//               cycle after any load that had to be clamped.
//   undefined : values pass through unchanged and clamp_flag stays 0.
//
// Handshake: change_*_req are single-cycle pulses sampled on the rising
// edge; the matching *_in value must be valid in that same cycle. There is
// no back-pressure: a newer request for a still-pending field overwrites
// its shadow (last value wins).
module discharge_param_scheduler #(
  parameter logic [15:0] TON_RST       = 16'd50,
  parameter logic [15:0] TOFF_RST      = 16'd200,
  parameter logic [15:0] IP_RST        = 16'd10,
  parameter logic [15:0] WAVE_RST      = 16'h2001,
  parameter logic [15:0] TON_MIN       = 16'd1,
  parameter logic [15:0] TON_MAX       = 16'd1000,
  parameter logic [15:0] TOFF_MIN      = 16'd5,
  parameter logic [15:0] IP_MAX        = 16'd70,
  parameter logic [15:0] STALE_TIMEOUT = 16'd50000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        change_ton_req,
  input  logic        change_toff_req,
  input  logic        change_ip_req,
  input  logic        change_waveform_req,
  input  logic [15:0] ton_in,
  input  logic [15:0] toff_in,
  input  logic [15:0] ip_in,
  input  logic [15:0] waveform_in,
  input  logic        is_machine,
  input  logic        pulse_off,
  output logic [15:0] ton_out,
  output logic [15:0] toff_out,
  output logic [15:0] ip_out,
  output logic [15:0] waveform_out,
  output logic        update_strobe,
  output logic [3:0]  pending,
  output logic        clamp_flag,
  output logic        stale_flag,
  output logic [1:0]  state_dbg_o
);

  // Field index order matches the pending vector: {wave, ip, toff, ton}.
  localparam int F_TON  = 0;
  localparam int F_TOFF = 1;
  localparam int F_IP   = 2;
  localparam int F_WAVE = 3;

`ifdef PARAM_CLAMP_EN
  localparam bit CLAMP_EN = 1'b1;
`else
  localparam bit CLAMP_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_SETTLE = 2'd2
  } state_t;

  localparam logic [3:0][15:0] RST_VEC = {WAVE_RST, IP_RST, TOFF_RST, TON_RST};

  state_t           state_q, state_d;
  logic [3:0]       req_vec;
  logic [3:0][15:0] in_vec;
  logic [3:0][15:0] load_vec;
  logic [3:0]       clamped;
  logic [3:0]       elig;
  logic [3:0]       commit;
  logic [3:0]       pending_q, pending_d;
  logic [3:0][15:0] shadow_q, shadow_d;
  logic [3:0][15:0] out_q, out_d;
  logic             strobe_q, strobe_d;
  logic             clamp_q, clamp_d;
  logic [15:0]      stale_cnt_q, stale_cnt_d;
  logic             stale_q, stale_d;

  // Range limit for one field; only the three power-related fields have limits.
  function automatic logic [15:0] clamp_field(input int idx, input logic [15:0] v);
    logic [15:0] r;
    r = v;
    case (idx)
      F_TON: begin
        if (v < TON_MIN)      r = TON_MIN;
        else if (v > TON_MAX) r = TON_MAX;
      end
      F_TOFF: if (v < TOFF_MIN) r = TOFF_MIN;
      F_IP:   if (v > IP_MAX)   r = IP_MAX;
      default: r = v;
    endcase
    return r;
  endfunction

  // Gather request pulses and values into indexable vectors.
  always_comb begin
    req_vec = {change_waveform_req, change_ip_req, change_toff_req, change_ton_req};
    in_vec  = {waveform_in, ip_in, toff_in, ton_in};
  end

  // Value actually written into each shadow, and whether limiting changed it.
  always_comb begin
    load_vec = in_vec;
    clamped  = '0;
    for (int f = 0; f < 4; f++) begin
      if (CLAMP_EN) begin
        load_vec[f] = clamp_field(f, in_vec[f]);
        clamped[f]  = req_vec[f] && (load_vec[f] != in_vec[f]);
      end
    end
    clamp_d = |clamped;
  end

  // Safe-window eligibility and the set of fields committing this edge.
  always_comb begin
    elig[F_TON]  = !is_machine || pulse_off;
    elig[F_TOFF] = !is_machine || pulse_off;
    elig[F_IP]   = !is_machine || pulse_off;
    elig[F_WAVE] = !is_machine;
    commit       = (state_q == ST_WAIT) ? (pending_q & elig) : 4'b0000;
  end

  // Shadow, pending and output next-state; a same-edge request re-arms pending.
  always_comb begin
    shadow_d  = shadow_q;
    out_d     = out_q;
    pending_d = (pending_q & ~commit) | req_vec;
    for (int f = 0; f < 4; f++) begin
      if (commit[f])  out_d[f]    = shadow_q[f];
      if (req_vec[f]) shadow_d[f] = load_vec[f];
    end
  end

  // Scheduler FSM next state; strobe mirrors entry into SETTLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (pending_d != 4'b0000) state_d = ST_WAIT;
      ST_WAIT:   if (commit != 4'b0000)    state_d = ST_SETTLE;
      ST_SETTLE: state_d = (pending_d != 4'b0000) ? ST_WAIT : ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
    strobe_d = (state_d == ST_SETTLE);
  end

  // Stale watchdog: saturating count of WAIT cycles without a commit.
  always_comb begin
    stale_cnt_d = stale_cnt_q;
    stale_d     = stale_q;
    if (commit != 4'b0000) begin
      stale_cnt_d = '0;
      stale_d     = 1'b0;
    end else if (state_q == ST_WAIT) begin
      if (stale_cnt_q < STALE_TIMEOUT) stale_cnt_d = stale_cnt_q + 16'd1;
      stale_d = (stale_cnt_d == STALE_TIMEOUT);
    end
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      pending_q   <= '0;
      shadow_q    <= RST_VEC;
      out_q       <= RST_VEC;
      strobe_q    <= 1'b0;
      clamp_q     <= 1'b0;
      stale_cnt_q <= '0;
      stale_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      shadow_q    <= shadow_d;
      out_q       <= out_d;
      strobe_q    <= strobe_d;
      clamp_q     <= clamp_d;
      stale_cnt_q <= stale_cnt_d;
      stale_q     <= stale_d;
    end
  end

  assign ton_out       = out_q[F_TON];
  assign toff_out      = out_q[F_TOFF];
  assign ip_out        = out_q[F_IP];
  assign waveform_out  = out_q[F_WAVE];
  assign pending       = pending_q;
  assign update_strobe = strobe_q;
  assign clamp_flag    = clamp_q;
  assign stale_flag    = stale_q;
  assign state_dbg_o   = state_q;

endmodule

// File: tb/tb_discharge_param_scheduler.sv
// Bench for discharge_param_scheduler: directed scenarios plus random
// traffic, all checked every cycle against a field-level reference model.
// Build with +define+PARAM_CLAMP_EN to exercise the clamping variant.
module tb_discharge_param_scheduler;

  localparam logic [15:0] ST_TO = 16'd50000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        change_ton_req = 1'b0, change_toff_req = 1'b0;
  logic        change_ip_req = 1'b0, change_waveform_req = 1'b0;
  logic [15:0] ton_in = '0, toff_in = '0, ip_in = '0, waveform_in = '0;
  logic        is_machine = 1'b0, pulse_off = 1'b0;
  logic [15:0] ton_out, toff_out, ip_out, waveform_out;
  logic        update_strobe, clamp_flag, stale_flag;
  logic [3:0]  pending;
  logic [1:0]  state_dbg;

  int total = 0;
  int bad   = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  discharge_param_scheduler #(.STALE_TIMEOUT(ST_TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .change_ton_req(change_ton_req), .change_toff_req(change_toff_req),
    .change_ip_req(change_ip_req), .change_waveform_req(change_waveform_req),
    .ton_in(ton_in), .toff_in(toff_in), .ip_in(ip_in), .waveform_in(waveform_in),
    .is_machine(is_machine), .pulse_off(pulse_off),
    .ton_out(ton_out), .toff_out(toff_out), .ip_out(ip_out), .waveform_out(waveform_out),
    .update_strobe(update_strobe), .pending(pending),
    .clamp_flag(clamp_flag), .stale_flag(stale_flag), .state_dbg_o(state_dbg)
  );

  // ---------------- reference model ----------------
  // Fields: 0 ton, 1 toff, 2 ip, 3 waveform.
  logic [15:0] m_out[4];
  logic [15:0] m_shad[4];
  bit          m_pend[4];
  bit          m_settle, m_clamp, m_stale;
  int          m_cnt;

  function automatic logic [15:0] m_limit(input int f, input logic [15:0] v);
`ifdef PARAM_CLAMP_EN
    if (f == 0) return (v < 16'd1) ? 16'd1 : ((v > 16'd1000) ? 16'd1000 : v);
    if (f == 1) return (v < 16'd5) ? 16'd5 : v;
    if (f == 2) return (v > 16'd70) ? 16'd70 : v;
`endif
    return v;
  endfunction

  task automatic m_reset();
    m_out[0] = 16'd50;  m_out[1] = 16'd200; m_out[2] = 16'd10; m_out[3] = 16'h2001;
    for (int f = 0; f < 4; f++) begin
      m_shad[f] = m_out[f];
      m_pend[f] = 1'b0;
    end
    m_settle = 1'b0; m_clamp = 1'b0; m_stale = 1'b0; m_cnt = 0;
  endtask

  // One clock edge of the rules: commit window, last-wins shadows, watchdog.
  task automatic m_step();
    bit          req[4];
    logic [15:0] val[4];
    bit          waiting, any_commit, com[4], clip;
    if (!rst_n) begin
      m_reset();
      return;
    end
    req[0] = change_ton_req; req[1] = change_toff_req;
    req[2] = change_ip_req;  req[3] = change_waveform_req;
    val[0] = ton_in; val[1] = toff_in; val[2] = ip_in; val[3] = waveform_in;
    waiting = !m_settle && (m_pend[0] || m_pend[1] || m_pend[2] || m_pend[3]);
    any_commit = 1'b0;
    for (int f = 0; f < 4; f++) begin
      com[f] = waiting && m_pend[f] && ((f == 3) ? !is_machine : (!is_machine || pulse_off));
      if (com[f]) begin
        m_out[f] = m_shad[f];
        any_commit = 1'b1;
      end
    end
    if (any_commit) begin
      m_cnt = 0; m_stale = 1'b0;
    end else if (waiting) begin
      if (m_cnt < int'(ST_TO)) m_cnt++;
      m_stale = (m_cnt == int'(ST_TO));
    end
    clip = 1'b0;
    for (int f = 0; f < 4; f++) begin
      m_pend[f] = (m_pend[f] && !com[f]) || req[f];
      if (req[f]) begin
        m_shad[f] = m_limit(f, val[f]);
        if (m_shad[f] != val[f]) clip = 1'b1;
      end
    end
    m_clamp  = clip;
    m_settle = any_commit;
  endtask

  // ---------------- scoreboard ----------------
  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("ton_out", ton_out, m_out[0]);
    chk("toff_out", toff_out, m_out[1]);
    chk("ip_out", ip_out, m_out[2]);
    chk("waveform_out", waveform_out, m_out[3]);
    chk("pending", {12'd0, pending}, {12'd0, m_pend[3], m_pend[2], m_pend[1], m_pend[0]});
    chk("update_strobe", {15'd0, update_strobe}, {15'd0, m_settle});
    chk("clamp_flag", {15'd0, clamp_flag}, {15'd0, m_clamp});
    chk("stale_flag", {15'd0, stale_flag}, {15'd0, m_stale});
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    m_step();
    #1;
    check_all();
  endtask

  task automatic clear_reqs();
    change_ton_req = 0; change_toff_req = 0; change_ip_req = 0; change_waveform_req = 0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    m_reset();
    rst_n = 0;
    ticks(2);
    chk("rst_ton", ton_out, 16'd50);
    chk("rst_wave", waveform_out, 16'h2001);
    rst_n = 1;
    tick();

    // Idle machine: request commits on the next edge with one strobe.
    is_machine = 0;
    ton_in = 16'd120; change_ton_req = 1;
    tick();
    clear_reqs();
    chk("t030_pend", {12'd0, pending}, 16'h0001);
    tick();
    chk("t030_ton", ton_out, 16'd120);
    chk("t030_strobe", {15'd0, update_strobe}, 16'd1);
    ticks(2);

    // Machining without deion window: Toff waits for pulse_off.
    is_machine = 1; pulse_off = 0;
    toff_in = 16'd300; change_toff_req = 1;
    tick();
    clear_reqs();
    ticks(5);
    chk("t031_pend", {12'd0, pending}, 16'h0002);
    chk("t031_toff_old", toff_out, 16'd200);
    pulse_off = 1;
    tick();
    chk("t031_toff", toff_out, 16'd300);
    ticks(3);

    // Waveform blocked by machining while Ip commits in the deion window.
    waveform_in = 16'h8000; change_waveform_req = 1;
    ip_in = 16'd40; change_ip_req = 1;
    tick();
    clear_reqs();
    ticks(4);
    chk("t032_ip", ip_out, 16'd40);
    chk("t032_pend", {12'd0, pending}, 16'h0008);
    is_machine = 0;
    ticks(3);
    chk("t032_wave", waveform_out, 16'h8000);

    // Out-of-range values.
    ip_in = 16'd100; change_ip_req = 1;
    ton_in = 16'd0;  change_ton_req = 1;
    tick();
    clear_reqs();
    ticks(3);
`ifdef PARAM_CLAMP_EN
    chk("t033_ip", ip_out, 16'd70);
    chk("t033_ton", ton_out, 16'd1);
`else
    chk("t033_ip", ip_out, 16'd100);
    chk("t033_ton", ton_out, 16'd0);
`endif

    // Same-field request on a commit edge: old shadow commits, new stays pending.
    is_machine = 1; pulse_off = 0;
    ton_in = 16'd11; change_ton_req = 1;
    tick();
    ton_in = 16'd22; pulse_off = 1;
    tick();
    clear_reqs();
    chk("t023_ton", ton_out, 16'd11);
    ticks(4);
    chk("t023_ton2", ton_out, 16'd22);

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      change_ton_req      = ($urandom_range(0, 3) == 0);
      change_toff_req     = ($urandom_range(0, 3) == 0);
      change_ip_req       = ($urandom_range(0, 3) == 0);
      change_waveform_req = ($urandom_range(0, 5) == 0);
      ton_in      = 16'($urandom_range(0, 1200));
      toff_in     = 16'($urandom_range(0, 400));
      ip_in       = 16'($urandom_range(0, 120));
      waveform_in = 16'($urandom);
      is_machine  = ($urandom_range(0, 2) != 0);
      pulse_off   = ($urandom_range(0, 2) == 0);
      tick();
    end
    clear_reqs();
    is_machine = 0;
    ticks(4);

    // Reset in WAIT with three pending fields discards them.
    is_machine = 1; pulse_off = 0;
    ton_in = 16'd7; toff_in = 16'd77; ip_in = 16'd33;
    change_ton_req = 1; change_toff_req = 1; change_ip_req = 1;
    tick();
    clear_reqs();
    chk("t035_pend_pre", {12'd0, pending}, 16'h0007);
    rst_n = 0; change_ton_req = 1;
    tick();
    clear_reqs();
    rst_n = 1;
    chk("t035_ton", ton_out, 16'd50);
    chk("t035_toff", toff_out, 16'd200);
    chk("t035_ip", ip_out, 16'd10);
    chk("t035_wave", waveform_out, 16'h2001);
    chk("t035_pend", {12'd0, pending}, 16'h0000);
    chk("t035_strobe", {15'd0, update_strobe}, 16'd0);
    ticks(3);

    // Long blocked request raises the stale flag; the next commit clears it.
    ip_in = 16'd20; change_ip_req = 1;
    tick();
    clear_reqs();
    ticks(int'(ST_TO) + 3);
    chk("t034_stale", {15'd0, stale_flag}, 16'd1);
    pulse_off = 1;
    tick();
    chk("t034_clear", {15'd0, stale_flag}, 16'd0);
    chk("t034_ip", ip_out, 16'd20);
    ticks(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/discharge_param_scheduler.md
DISCHARGE_PARAM_SCHEDULER -- requirements
Module: discharge_param_scheduler

Interface
REQ-001 SHALL have parameter TON_RST, default 16'd50, Ton loaded at reset.
REQ-002 SHALL have parameter TOFF_RST, default 16'd200, Toff loaded at reset.
REQ-003 SHALL have parameter IP_RST, default 16'd10, Ip loaded at reset.
REQ-004 SHALL have parameter WAVE_RST, default 16'h2001, waveform word loaded at reset.
REQ-005 SHALL have parameter TON_MIN/TON_MAX, defaults 16'd1/16'd1000, Ton legal range.
REQ-006 SHALL have parameter TOFF_MIN, default 16'd5, minimum legal Toff.
REQ-007 SHALL have parameter IP_MAX, default 16'd70, maximum legal Ip (A).
REQ-008 SHALL have parameter STALE_TIMEOUT, default 16'd50000, wait cycles before stale flag.
REQ-009 SHALL have ports: clk in 1, single clock; rst_n in 1, synchronous active-low reset.
REQ-010 SHALL have ports: change_ton_req/change_toff_req/change_ip_req/change_waveform_req in 1 each, one-cycle request pulses.
REQ-011 SHALL have ports: ton_in/toff_in/ip_in/waveform_in in 16 each, values valid with their request.
REQ-012 SHALL have ports: is_machine in 1, machining active; pulse_off in 1, discharge_control is in Toff/deion (safe window).
REQ-013 SHALL have ports: ton_out/toff_out/ip_out/waveform_out out 16 each, committed registered values.
REQ-014 SHALL have ports: update_strobe out 1; pending out 4 {wave,ip,toff,ton}; clamp_flag out 1; stale_flag out 1.

Function
REQ-015 Request at edge N SHALL load the shadow register and set its pending bit at edge N; pending visible from cycle N+1.
REQ-016 Repeated request on a field already pending SHALL overwrite its shadow (last wins), pending stays set.
REQ-017 FSM states SHALL be IDLE (pending==0), WAIT (pending!=0), SETTLE (one cycle after a commit).
REQ-018 In WAIT, Ton/Toff/Ip SHALL be eligible when is_machine==0 or pulse_off==1; waveform eligible only when is_machine==0.
REQ-019 On an eligible WAIT cycle all eligible pending fields SHALL commit atomically on that edge, clear their pending bits, state -> SETTLE.
REQ-020 update_strobe SHALL be high exactly one cycle (SETTLE), with new outputs already visible in that cycle.
REQ-021 A pending waveform blocked by is_machine==1 SHALL stay pending while other eligible fields commit.
REQ-022 SETTLE SHALL not commit; next state WAIT if pending!=0, else IDLE.
REQ-023 A request coinciding with a commit edge for the same field SHALL win: shadow takes new value, pending stays set, previous shadow committed.
REQ-024 Stale counter SHALL count cycles in WAIT with no commit; at STALE_TIMEOUT it saturates and sets stale_flag, cleared at next commit.
REQ-025 All outputs SHALL be registered; no combinational path from inputs to outputs.

Reset
REQ-026 rst_n==0 at an edge SHALL set outputs to TON_RST/TOFF_RST/IP_RST/WAVE_RST, pending=0, shadows=reset values, strobe/flags=0, counter=0, state IDLE.
REQ-027 Reset mid-WAIT SHALL discard all pending requests; a request in the reset cycle is ignored.

Configuration
REQ-028 With PARAM_CLAMP_EN defined, shadows SHALL load clamped values (Ton to [TON_MIN,TON_MAX], Toff >= TOFF_MIN, Ip <= IP_MAX) and clamp_flag SHALL pulse one cycle after any clamped load.
REQ-029 Without PARAM_CLAMP_EN, values SHALL pass unchanged and clamp_flag SHALL be tied 0.

Verification
REQ-030 Reset, is_machine=0, ton_in=120 request -> pending=0001 next cycle, ton_out=120 with update_strobe=1 two cycles after request.
REQ-031 is_machine=1, pulse_off=0, toff_in=300 request -> ton/toff unchanged and pending=0010 until pulse_off=1; then toff_out=300, one strobe.
REQ-032 is_machine=1, pulse_off=1, waveform 16'h8000 plus ip 40 requested -> ip_out=40 commits, waveform pending until is_machine=0, then waveform_out=16'h8000.
REQ-033 PARAM_CLAMP_EN defined, ip_in=100 and ton_in=0 -> ip_out=70, ton_out=1, clamp_flag pulse; undefined -> 100 and 0, clamp_flag 0.
REQ-034 Pending held with pulse_off=0, is_machine=1 for 50000 cycles -> stale_flag=1; next commit clears it.
REQ-035 rst_n low during WAIT with pending=0111 -> outputs return to 50/200/10/16'h2001, pending=0, no strobe.
